// File: rtl/hvac_actuator_ctrl.sv
// Actuator sequencer between the thermostat and the heater, cooler and fan.
// It enforces the minimum on-time, the fan run-on and the restart lockout.
module hvac_actuator_ctrl #(
   parameter int MIN_ON    = 8,
   parameter int FAN_RUNON = 4,
   parameter int MIN_OFF   = 6,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       heating,
   input  logic       cooling,
   output logic       heater_on,
   output logic       cooler_on,
   output logic       fan_on,
   output logic [2:0] state,
   output logic       fault
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] HEAT    = 3'd1;
   localparam logic [2:0] COOL    = 3'd2;
   localparam logic [2:0] RUNON   = 3'd3;
   localparam logic [2:0] LOCKOUT = 3'd4;

   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(FAN_RUNON - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MIN_OFF - 1);

   logic [2:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic             heater_reg, cooler_reg, fan_reg, fault_reg;
   logic             heat_req, cool_req;

   // Contradictory demand is treated as no demand at all.
   assign heat_req = enable & heating & ~cooling;
   assign cool_req = enable & cooling & ~heating;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (heat_req)
               state_next = HEAT;
            else if (cool_req)
               state_next = COOL;
         end
         HEAT: begin
            if (!enable || (!heat_req && cnt_reg >= ON_LAST))
               state_next = RUNON;
         end
         COOL: begin
            if (!enable || (!cool_req && cnt_reg >= ON_LAST))
               state_next = RUNON;
         end
         RUNON: begin
            if (cnt_reg == RUN_LAST)
               state_next = LOCKOUT;
         end
         LOCKOUT: begin
            if (cnt_reg == LOCK_LAST)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_reg.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         heater_reg <= 1'b0;
         cooler_reg <= 1'b0;
         fan_reg    <= 1'b0;
         fault_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         if (state_next != state_reg)
            cnt_reg <= '0;
         else if (cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + 1'b1;
         heater_reg <= (state_next == HEAT);
         cooler_reg <= (state_next == COOL);
         fan_reg    <= (state_next == HEAT) || (state_next == COOL) ||
                       (state_next == RUNON);
         fault_reg  <= heating & cooling;
      end
   end

   assign heater_on = heater_reg;
   assign cooler_on = cooler_reg;
   assign fan_on    = fan_reg;
   assign state     = state_reg;
   assign fault     = fault_reg;

endmodule

// File: doc/hvac_actuator_ctrl.md
Name: hvac_actuator_ctrl

Overview:
- Downstream stage of the AC thermostat block: consumes its `heating`/`cooling` demand bits and drives the physical heater, cooler and fan outputs.
- Enforces actuator protection rules the thermostat does not:
  - minimum on-time;
  - fan run-on after a run;
  - minimum off (lockout) time before any restart, which also acts as changeover dead time.
- Rejects the illegal demand where both requests are high.

Parameters:
- MIN_ON, 8: minimum cycles heater/cooler stays on once started (>=1).
- FAN_RUNON, 4: cycles fan keeps running after heater/cooler switches off (>=1).
- MIN_OFF, 6: lockout cycles with everything off before the next start (>=1).
- CNT_W, 8: width of the internal state-time counter; every timing parameter must be <= 2^CNT_W-1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- enable, input, 1: master enable; low forces shutdown sequence.
- heating, input, 1: heat demand from thermostat.
- cooling, input, 1: cool demand from thermostat.
- heater_on, output, 1: heater actuator drive.
- cooler_on, output, 1: cooler actuator drive.
- fan_on, output, 1: fan drive.
- state, output, 3: current FSM state code.
- fault, output, 1: high while `heating` and `cooling` were both high at last sample.

Behaviour:
- All outputs are registered; nothing is combinational from inputs.
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0, every output 0.
  - Reset mid-operation turns actuators off on that edge.
  - No lockout is applied after reset.
- Derived requests, evaluated each posedge:
  - heat_req = enable & heating & ~cooling
  - cool_req = enable & cooling & ~heating
  - Both demands high counts as no request.
- fault <= heating & cooling every cycle, independent of state and enable.
- cnt:
  - Clears to 0 on every state change.
  - Otherwise increments by 1, saturating at 2^CNT_W-1.
- State codes: IDLE=0, HEAT=1, COOL=2, RUNON=3, LOCKOUT=4; codes 5-7 go to IDLE on the next edge.
- Transitions (one per posedge):
  - IDLE: heat_req -> HEAT; else cool_req -> COOL; else stay. heat_req and cool_req are mutually exclusive.
  - HEAT:
    - ~enable -> RUNON immediately (enable overrides MIN_ON).
    - ~heat_req and cnt>=MIN_ON-1 -> RUNON.
    - Otherwise stay. A request drop before MIN_ON is ignored.
  - COOL: same rules as HEAT, using cool_req.
  - RUNON: cnt==FAN_RUNON-1 -> LOCKOUT.
  - LOCKOUT: cnt==MIN_OFF-1 -> IDLE. Requests are ignored during LOCKOUT.
- HEAT->COOL is never direct: a changeover always passes through RUNON+LOCKOUT+IDLE.
- Output decode, from the registered state:
  - IDLE: heater_on 0, cooler_on 0, fan_on 0.
  - HEAT: heater_on 1, cooler_on 0, fan_on 1.
  - COOL: heater_on 0, cooler_on 1, fan_on 1.
  - RUNON: heater_on 0, cooler_on 0, fan_on 1.
  - LOCKOUT: heater_on 0, cooler_on 0, fan_on 0.
  - heater_on and cooler_on are never high together.
- Latency:
  - Request high in IDLE before edge N -> heater_on/cooler_on high from edge N.
  - Actuator on-time is >= MIN_ON cycles unless enable drops.
  - After a drop-out: fan on for exactly FAN_RUNON cycles, then all off for exactly MIN_OFF cycles, then IDLE for >=1 cycle before a restart.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then heating=cooling=0, enable=1 -> all outputs 0, state=0 for 10 cycles.
- Basic heat run with defaults:
  - Stimulus: enable=1, heating=1 for 3 cycles, then 0.
  - Expect heater_on=1 for exactly 8 cycles (MIN_ON).
  - Then fan-only (state=3) for 4 cycles.
  - Then state=4 with all outputs 0 for 6 cycles.
  - Then state=0.
- Long cool run: cooling=1 for 20 cycles -> cooler_on high for 20 cycles; after cooling drops, RUNON 4 cycles, then LOCKOUT 6 cycles.
- Changeover:
  - Stimulus: heating=1 for 10 cycles, then heating=0 with cooling=1 at the same edge.
  - Expect heater off, then 4 fan cycles, then 6 off cycles, then 1 IDLE cycle.
  - Expect cooler_on=1 on the edge after that; heater_on&cooler_on never both 1.
- Illegal demand: heating=cooling=1 in IDLE -> fault=1 from the next edge; state stays 0. Both high during HEAT -> treated as request drop; RUNON once cnt>=7.
- Enable and reset overrides:
  - enable=0 at cycle 2 of HEAT -> RUNON on the next edge (MIN_ON bypassed).
  - rst=1 during COOL -> all outputs 0 and state=0 on the next edge; a new cooling=1 restarts without lockout.
